step_counter: RTL
=================

Name: step_counter

Overview:
Parametrised registered counter with programmable step, direction, modulus and wrap/saturate mode. It is the generalised successor of the fixed 3-bit-operand clocked adder/counter. It provides synchronous clear, parallel load, a carry/borrow pulse and a sticky overflow flag. It serves as a general event/cycle counter in the datapath and for test fixtures.

Parameters:
WIDTH, 4, width of count register.
STEP_W, 3, width of step operand.
MODULUS, 16, count range is 0..MODULUS-1. Legal range: 2^STEP_W <= MODULUS <= 2^WIDTH.
SATURATE, 0, 0 = wrap modulo MODULUS; 1 = clamp at 0 / MODULUS-1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear; highest priority
load  in  1  synchronous parallel load
load_val  in  WIDTH  load value
en  in  1  count enable
dir  in  1  1 = up, 0 = down
step  in  STEP_W  increment/decrement amount (unsigned)
count  out  WIDTH  registered count value
carry  out  1  registered; high for one cycle when the update wrapped or clamped
zero  out  1  combinational; count == 0
ovf_sticky  out  1  registered; set on any carry, held until clr or reset

Behaviour:
- Reset (rst_n low, asynchronous, any time): count = 0, carry = 0, ovf_sticky = 0; zero = 1. The first update follows the first rising edge after rst_n rises.
- Priority at each rising edge: clr > load > en > hold.
- clr: count <= 0, carry <= 0, ovf_sticky <= 0.
- load: count <= load_val if load_val < MODULUS, else MODULUS-1. carry <= 0. ovf_sticky unchanged.
- en, up: raw = count + step, computed in WIDTH+1 bits.
  - raw < MODULUS: count <= raw, carry <= 0.
  - raw >= MODULUS, SATURATE=0: count <= raw - MODULUS, carry <= 1.
  - raw >= MODULUS, SATURATE=1: count <= MODULUS-1, carry <= 1.
- en, down:
  - count >= step: count <= count - step, carry <= 0.
  - count < step, SATURATE=0: count <= count + MODULUS - step, computed in WIDTH+1 bits. carry <= 1.
  - count < step, SATURATE=1: count <= 0, carry <= 1.
- Saturated at a limit with step > 0 toward that limit: count holds and carry pulses every enabled cycle.
- step = 0 with en: count holds, carry <= 0.
- en low, no clr/load: count holds, carry <= 0.
- carry is a single-cycle pulse aligned with the edge that updates count. Consecutive wrapping cycles give consecutive carry highs.
- ovf_sticky <= ovf_sticky | next carry. It is only cleared by clr or reset.
- Latency: all inputs are sampled on the rising edge; count and carry are valid immediately after that edge. No combinational path from inputs to count, carry or ovf_sticky.
- Reset asserted mid-count: all outputs go to reset values immediately, without waiting for clk.
- No X propagation: step, dir and load_val are ignored when neither en nor load is active.

Test Plan:
- Reset/hold: rst_n low at t=0, released at 100 ns, en=0 for 5 cycles -> count=0, zero=1, carry=0, ovf_sticky=0 throughout.
- Wrap up (defaults): load 13, then en=1, dir=1, step=5 -> count 13 -> 2 (carry=1) -> 7 (carry=0) -> 12 -> 1 (carry=1). ovf_sticky=1 from the first wrap.
- Wrap down: load 2, en=1, dir=0, step=3 -> count 2 -> 15 (carry=1) -> 12 (carry=0). With MODULUS=10: 2 -> 9 (carry=1).
- Saturate (SATURATE=1, MODULUS=10): load 8, step=3, dir=1 -> count 9 with carry=1, then 9 with carry=1 each cycle. dir=0 from 1, step=4 -> count 0, carry=1.
- Priority: clr=1, load=1, en=1 on the same edge -> count=0, ovf_sticky cleared. load=1, en=1, load_val=6 -> count=6, not 6+step. load_val=12 with MODULUS=10 -> count=9.
- Async reset mid-operation: counting at count=7 with ovf_sticky=1, rst_n pulsed low between clock edges -> count=0 and ovf_sticky=0 before the next edge. Counting resumes from 0 after release.

Source files
------------

// File: rtl/step_counter.sv
// ---------------------------------------------------------------------------
// step_counter
//   Registered counter over the range 0..MODULUS-1 with a programmable step,
//   a direction select and a choice of wrap-around or clamping at the limits.
//   It provides synchronous clear, parallel load, a one-cycle carry/borrow
//   pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    : width of the count register
//   STEP_W   : width of the step operand (unsigned)
//   MODULUS  : count range is 0..MODULUS-1, 2**STEP_W <= MODULUS <= 2**WIDTH
//   SATURATE : 0 = wrap modulo MODULUS, 1 = clamp at 0 / MODULUS-1
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous clear, highest priority
//   load       in   synchronous parallel load (clamped to MODULUS-1)
//   load_val   in   WIDTH-bit load value
//   en         in   count enable
//   dir        in   1 = up, 0 = down
//   step       in   STEP_W-bit increment/decrement amount
//   count      out  registered count value
//   carry      out  registered one-cycle pulse when an update wrapped/clamped
//   zero       out  combinational, count == 0
//   ovf_sticky out  registered, set by any carry, cleared by clr or reset
// ---------------------------------------------------------------------------

// Invariant checker for the counter; holds only assertions, no logic.
module step_counter_chk #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic             clk,
    input logic             rst_n,
    input logic             clr,
    input logic             load,
    input logic             en,
    input logic [WIDTH-1:0] count,
    input logic             carry,
    input logic             zero,
    input logic             ovf_sticky
);
    localparam logic [WIDTH:0] MOD_X = (WIDTH + 1)'(MODULUS);

    // The count never leaves the legal range.
    a_count_range : assert property (
        @(posedge clk) disable iff (!rst_n) ({1'b0, count} < MOD_X)
    );

    // A carry can only come from an enabled count that clr/load did not override.
    a_carry_source : assert property (
        @(posedge clk) disable iff (!rst_n) carry |-> $past(en & ~clr & ~load)
    );

    // Every carry is reflected in the sticky flag.
    a_carry_sticky : assert property (
        @(posedge clk) disable iff (!rst_n) carry |-> ovf_sticky
    );

    // The zero flag tracks the count.
    a_zero_flag : assert property (
        @(posedge clk) disable iff (!rst_n) zero == (count == {WIDTH{1'b0}})
    );
endmodule

module step_counter #(
    parameter int WIDTH    = 4,
    parameter int STEP_W   = 3,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              carry,
    output logic              zero,
    output logic              ovf_sticky
);
    // Arithmetic is done one bit wider than the count so that count+step and
    // count+MODULUS-step never overflow before they are compared/reduced.
    localparam int              XW    = WIDTH + 1;
    localparam logic [WIDTH:0]  MOD_X = XW'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic            SAT_C = (SATURATE != 0) ? 1'b1 : 1'b0;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             carry_q;
    logic             carry_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [WIDTH:0]   cnt_x_s;
    logic [WIDTH:0]   step_x_s;
    logic [WIDTH:0]   up_raw_s;
    logic [WIDTH-1:0] up_cnt_s;
    logic             up_wrap_s;
    logic             dn_borrow_s;
    logic [WIDTH-1:0] dn_cnt_s;
    logic [WIDTH-1:0] load_cnt_s;

    assign cnt_x_s  = {1'b0, count_q};
    assign step_x_s = XW'(step);
    assign up_raw_s = cnt_x_s + step_x_s;

    // Up-count candidate: in range, wrapped, or clamped at the top.
    always_comb begin
        up_cnt_s  = up_raw_s[WIDTH-1:0];
        up_wrap_s = 1'b0;
        if (up_raw_s < MOD_X) begin
            up_cnt_s  = up_raw_s[WIDTH-1:0];
            up_wrap_s = 1'b0;
        end else begin
            up_wrap_s = 1'b1;
            if (SAT_C) begin
                up_cnt_s = MAX_C;
            end else begin
                // raw < 2*MODULUS, so a single subtraction lands in range.
                up_cnt_s = WIDTH'(up_raw_s - MOD_X);
            end
        end
    end

    // Down-count candidate: in range, wrapped, or clamped at zero.
    always_comb begin
        dn_borrow_s = (cnt_x_s < step_x_s);
        dn_cnt_s    = count_q;
        if (!dn_borrow_s) begin
            dn_cnt_s = WIDTH'(cnt_x_s - step_x_s);
        end else begin
            if (SAT_C) begin
                dn_cnt_s = {WIDTH{1'b0}};
            end else begin
                // Adding MODULUS first keeps the intermediate non-negative.
                dn_cnt_s = WIDTH'(cnt_x_s + MOD_X - step_x_s);
            end
        end
    end

    // Out-of-range load values clamp to the top of the count range.
    always_comb begin
        load_cnt_s = MAX_C;
        if ({1'b0, load_val} < MOD_X) begin
            load_cnt_s = load_val;
        end else begin
            load_cnt_s = MAX_C;
        end
    end

    // Next-state selection with priority clr > load > en > hold.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
            carry_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_cnt_s;
            carry_d = 1'b0;
            ovf_d   = ovf_q;
        end else if (en) begin
            if (dir) begin
                count_d = up_cnt_s;
                carry_d = up_wrap_s;
            end else begin
                count_d = dn_cnt_s;
                carry_d = dn_borrow_s;
            end
            ovf_d = ovf_q | carry_d;
        end else begin
            count_d = count_q;
            carry_d = 1'b0;
            ovf_d   = ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign carry      = carry_q;
    assign ovf_sticky = ovf_q;
    assign zero       = (count_q == {WIDTH{1'b0}});

    step_counter_chk #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (load),
        .en         (en),
        .count      (count_q),
        .carry      (carry_q),
        .zero       (zero),
        .ovf_sticky (ovf_q)
    );
endmodule
